// File: rtl/force_ring_drain_ctrl_pkg.sv
// force_ring_drain_ctrl_pkg: state encoding and phase timing constants for the force-ring drain controller
package force_ring_drain_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, EVAL, DRAIN, QUIET, DONE, ERR} force_ring_ctrl_state_t;

    localparam int FORCE_RING_LATENCY  = 16;
    localparam int FORCE_PHASE_TIMEOUT = 65535;

    function automatic logic is_active(input force_ring_ctrl_state_t s);
        return s == EVAL || s == DRAIN || s == QUIET;
    endfunction

endpackage

// File: rtl/force_ring_drain_ctrl.sv
// force_ring_drain_ctrl: sequences a force phase, waits for PE completion and a quiet ring, guards with a timeout
module force_ring_drain_ctrl
    import force_ring_drain_ctrl_pkg::*;
#(
    parameter int NUM_NODES      = 8,
    parameter int RING_LATENCY   = FORCE_RING_LATENCY,
    parameter int TIMEOUT_CYCLES = FORCE_PHASE_TIMEOUT,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [NUM_NODES-1:0] i_pe_done,
    input  logic [NUM_NODES-1:0] i_buffer_empty,
    input  logic [NUM_NODES-1:0] i_ring_valid,
    input  logic [NUM_NODES-1:0] i_cache_wr_valid,
    output logic                 o_pe_enable,
    output logic                 o_ring_busy,
    output logic                 o_force_done,
    output logic                 o_timeout,
    output logic                 o_error,
    output logic [2:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_cycle_count
);
    localparam int QW = $clog2(RING_LATENCY + 1);

    force_ring_ctrl_state_t state_q, state_d, norm_d;
    logic [NUM_NODES-1:0] done_mask_q, done_mask_d;
    logic [QW-1:0]        quiet_cnt_q, quiet_cnt_d;
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic                 timeout_q;
    logic                 quiet, active, start_ok, expired;

    assign quiet    = &i_buffer_empty & ~|i_ring_valid & ~|i_cache_wr_valid;
    assign active   = is_active(state_q);
    assign start_ok = i_start && (state_q == IDLE || state_q == ERR);
    assign expired  = active && cycle_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    // Next-state logic: the normal phase sequence, overridden by the timeout unless the phase completes
    always_comb begin
        norm_d      = state_q;
        done_mask_d = done_mask_q;
        quiet_cnt_d = quiet_cnt_q;
        case (state_q)
            IDLE, ERR: if (i_start) begin
                norm_d      = EVAL;
                done_mask_d = '0;
            end
            EVAL: begin
                done_mask_d = done_mask_q | i_pe_done;
                norm_d      = &done_mask_d ? DRAIN : EVAL;
            end
            DRAIN: if (quiet) begin
                norm_d      = QUIET;
                quiet_cnt_d = '0;
            end
            QUIET: if (!quiet) begin
                norm_d      = DRAIN;
                quiet_cnt_d = '0;
            end else if (quiet_cnt_q == QW'(RING_LATENCY - 1)) begin
                norm_d      = DONE;
            end else begin
                quiet_cnt_d = quiet_cnt_q + QW'(1);
            end
            default: norm_d = IDLE;
        endcase
        state_d     = (expired && norm_d != DONE) ? ERR : norm_d;
        cycle_cnt_d = start_ok ? '0 : active ? cycle_cnt_q + CNT_WIDTH'(1) : cycle_cnt_q;
    end

    // State and counter registers; the timeout flag marks only the first ERR cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            done_mask_q <= '0;
            quiet_cnt_q <= '0;
            cycle_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_mask_q <= done_mask_d;
            quiet_cnt_q <= quiet_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            timeout_q   <= state_d == ERR && state_q != ERR;
        end
    end

    assign o_pe_enable   = state_q == EVAL;
    assign o_ring_busy   = active;
    assign o_force_done  = state_q == DONE;
    assign o_timeout     = timeout_q;
    assign o_error       = state_q == ERR;
    assign o_state       = state_q;
    assign o_cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_force_ring_drain_ctrl.sv
// tb_force_ring_drain_ctrl: table-driven cycle vectors plus a reset-in-QUIET sequence
module tb_force_ring_drain_ctrl;
    localparam logic [2:0] S_IDLE = 3'd0, S_EVAL = 3'd1, S_DRAIN = 3'd2, S_QUIET = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5;

    logic        clk = 1'b0;
    logic        rst, i_start;
    logic [3:0]  i_pe_done, i_buffer_empty, i_ring_valid, i_cache_wr_valid;
    logic        o_pe_enable, o_ring_busy, o_force_done, o_timeout, o_error;
    logic [2:0]  o_state;
    logic [15:0] o_cycle_count;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic       start;
        logic [3:0] pd, emp, rv, cv;
        logic [2:0] st;
        logic       to;
        int         cnt;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    force_ring_drain_ctrl #(
        .NUM_NODES(4), .RING_LATENCY(8), .TIMEOUT_CYCLES(100), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_pe_done(i_pe_done),
        .i_buffer_empty(i_buffer_empty), .i_ring_valid(i_ring_valid), .i_cache_wr_valid(i_cache_wr_valid),
        .o_pe_enable(o_pe_enable), .o_ring_busy(o_ring_busy), .o_force_done(o_force_done),
        .o_timeout(o_timeout), .o_error(o_error), .o_state(o_state), .o_cycle_count(o_cycle_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [2:0] st, input int cnt, input logic start = 1'b0,
                                input logic [3:0] pd = 4'h0, input logic [3:0] emp = 4'hF,
                                input logic [3:0] rv = 4'h0, input logic [3:0] cv = 4'h0,
                                input logic to = 1'b0);
        vec_t v;
        v.st = st; v.cnt = cnt; v.start = start; v.pd = pd;
        v.emp = emp; v.rv = rv; v.cv = cv; v.to = to;
        vq.push_back(v);
    endfunction

    function automatic logic [3:0] pd_nom(input int k);
        return k == 3 ? 4'h1 : k == 5 ? 4'h2 : k == 6 ? 4'h4 : k == 9 ? 4'h8 : 4'h0;
    endfunction

    initial begin
        int done_seen;
        bit reached;
        // nominal phase: DRAIN at t0+10, QUIET t0+11..18, DONE t0+19 with count 18
        add(S_IDLE, 0, 1'b1);
        for (int k = 1; k <= 9; k++) add(S_EVAL, k - 1, 1'b0, pd_nom(k));
        add(S_DRAIN, 9);
        for (int k = 11; k <= 18; k++) add(S_QUIET, k - 1);
        add(S_DONE, 18);
        // ring activity in the 5th QUIET cycle pushes DONE out by 6 cycles
        add(S_IDLE, -1, 1'b1);
        for (int k = 1; k <= 9; k++) add(S_EVAL, k - 1, 1'b0, pd_nom(k));
        add(S_DRAIN, 9);
        for (int k = 11; k <= 15; k++) add(S_QUIET, k - 1, 1'b0, 4'h0, 4'hF, k == 15 ? 4'h4 : 4'h0);
        add(S_DRAIN, 15);
        for (int k = 17; k <= 24; k++) add(S_QUIET, k - 1);
        add(S_DONE, 24);
        // buffer 2 held non-empty through t0+30, then a cache write breaks the quiet window once
        add(S_IDLE, -1, 1'b1, 4'h0, 4'hB);
        for (int k = 1; k <= 9; k++) add(S_EVAL, k - 1, 1'b0, pd_nom(k), 4'hB);
        for (int k = 10; k <= 31; k++) add(S_DRAIN, k - 1, 1'b0, 4'h0, k <= 30 ? 4'hB : 4'hF);
        add(S_QUIET, 31);
        add(S_QUIET, 32, 1'b0, 4'h0, 4'hF, 4'h0, 4'h1);
        add(S_DRAIN, 33);
        for (int k = 35; k <= 42; k++) add(S_QUIET, k - 1);
        add(S_DONE, 42);
        // stale done flags before start, partial mask, start ignored in EVAL and DONE
        add(S_IDLE, -1, 1'b0, 4'hF);
        add(S_IDLE, -1, 1'b0, 4'hF);
        add(S_IDLE, -1, 1'b1, 4'hF);
        for (int k = 1; k <= 5; k++) add(S_EVAL, k - 1, k == 3, 4'h7);
        add(S_EVAL, 5, 1'b0, 4'h8);
        add(S_DRAIN, 6);
        for (int k = 8; k <= 15; k++) add(S_QUIET, k - 1);
        add(S_DONE, 15, 1'b1);
        // timeout: PE 3 never finishes; ERR at count 99, then restart and complete
        add(S_IDLE, -1, 1'b1);
        for (int k = 1; k <= 100; k++) add(S_EVAL, k - 1, 1'b0, 4'h7);
        add(S_ERR, 100, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        add(S_ERR, 100);
        add(S_ERR, 100);
        add(S_ERR, 100, 1'b1);
        add(S_EVAL, 0, 1'b0, 4'hF);
        add(S_DRAIN, 1);
        for (int k = 107; k <= 114; k++) add(S_QUIET, k - 105);
        add(S_DONE, 10);
        // last QUIET cycle coincides with the timeout cycle: DONE wins
        add(S_IDLE, -1, 1'b1);
        for (int k = 1; k <= 90; k++) add(S_EVAL, k - 1, 1'b0, 4'h7);
        add(S_EVAL, 90, 1'b0, 4'h8);
        add(S_DRAIN, 91);
        for (int k = 93; k <= 100; k++) add(S_QUIET, k - 1);
        add(S_DONE, 100);
        add(S_IDLE, -1);

        rst = 1'b1; i_start = 1'b0; i_pe_done = 4'h0;
        i_buffer_empty = 4'hF; i_ring_valid = 4'h0; i_cache_wr_valid = 4'h0;
        repeat (5) @(posedge clk);
        #1;
        check("reset state", 32'(o_state), 32'(S_IDLE));
        check("reset pe_enable", 32'(o_pe_enable), 0);
        check("reset busy", 32'(o_ring_busy), 0);
        check("reset done", 32'(o_force_done), 0);
        check("reset timeout", 32'(o_timeout), 0);
        check("reset error", 32'(o_error), 0);
        check("reset count", 32'(o_cycle_count), 0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            i_start = vq[i].start; i_pe_done = vq[i].pd; i_buffer_empty = vq[i].emp;
            i_ring_valid = vq[i].rv; i_cache_wr_valid = vq[i].cv;
            check($sformatf("v%0d state", i), 32'(o_state), 32'(vq[i].st));
            check($sformatf("v%0d pe_enable", i), 32'(o_pe_enable), 32'(vq[i].st == S_EVAL));
            check($sformatf("v%0d busy", i), 32'(o_ring_busy), 32'(vq[i].st inside {S_EVAL, S_DRAIN, S_QUIET}));
            check($sformatf("v%0d done", i), 32'(o_force_done), 32'(vq[i].st == S_DONE));
            check($sformatf("v%0d timeout", i), 32'(o_timeout), 32'(vq[i].to));
            check($sformatf("v%0d error", i), 32'(o_error), 32'(vq[i].st == S_ERR));
            if (vq[i].cnt >= 0) check($sformatf("v%0d count", i), 32'(o_cycle_count), 32'(vq[i].cnt));
            step();
        end

        // reset in the middle of QUIET: IDLE next cycle, counters cleared, no done pulse
        i_start = 1'b1; i_pe_done = 4'h0; i_buffer_empty = 4'hF; i_ring_valid = 4'h0; i_cache_wr_valid = 4'h0;
        step();
        i_start = 1'b0; i_pe_done = 4'hF;
        step();
        i_pe_done = 4'h0;
        reached = 1'b0;
        for (int n = 0; n < 10 && !reached; n++) begin
            if (o_state == S_QUIET) reached = 1'b1;
            else step();
        end
        check("rst seq reached QUIET", 32'(reached), 1);
        step();
        step();
        rst = 1'b1;
        step();
        check("rst seq state", 32'(o_state), 32'(S_IDLE));
        check("rst seq busy", 32'(o_ring_busy), 0);
        check("rst seq done", 32'(o_force_done), 0);
        check("rst seq timeout", 32'(o_timeout), 0);
        check("rst seq count", 32'(o_cycle_count), 0);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            done_seen += int'(o_force_done) + int'(o_timeout);
        end
        check("rst seq no pulses", 32'(done_seen), 0);
        check("rst seq idle after", 32'(o_state), 32'(S_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
